// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - register map, STATUS/CTRL bit positions and FSM states for uart_fifo
package uart_pkg;

   localparam logic [1:0] REG_CLK_DIV = 2'd0;
   localparam logic [1:0] REG_STATUS  = 2'd1;
   localparam logic [1:0] REG_DATA    = 2'd2;
   localparam logic [1:0] REG_CTRL    = 2'd3;

   localparam int ST_TX_NOT_FULL  = 0;
   localparam int ST_RX_NOT_EMPTY = 1;
   localparam int ST_TX_IDLE      = 2;
   localparam int ST_RX_OVERRUN   = 3;
   localparam int ST_RX_FRAMING   = 4;
   localparam int ST_RX_PARITY    = 5;
   localparam int ST_TX_OVERFLOW  = 6;

   localparam int CTRL_PARITY_EN  = 0;
   localparam int CTRL_PARITY_ODD = 1;
   localparam int CTRL_TWO_STOP   = 2;

   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

endpackage

// File: rtl/uart_fifo_if.sv
// rtl/uart_fifo_if.sv - peripheral register bus between address decoder and uart_fifo
interface uart_fifo_if;
   logic [63:0] address_in;
   logic        sel_in;
   logic        read_in;
   logic [63:0] read_value_out;
   logic [3:0]  write_mask_in;
   logic [63:0] write_value_in;

   modport master (output address_in, sel_in, read_in, write_mask_in, write_value_in,
                   input  read_value_out);
   modport slave  (input  address_in, sel_in, read_in, write_mask_in, write_value_in,
                   output read_value_out);
endinterface

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         push_data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         head_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

   // pointer and occupancy bookkeeping
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // storage array, written only on an accepted push
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
endmodule

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - FIFO-buffered UART with CLK_DIV/STATUS/DATA/CTRL registers
module uart_fifo import uart_pkg::*; #(
   parameter int          DATA_BITS     = 8,
   parameter int          FIFO_DEPTH    = 16,
   parameter logic [31:0] CLK_DIV_RESET = 32'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx_in,
   output logic        tx_out,
   uart_fifo_if.slave  bus
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int BW = $clog2(DATA_BITS);

   logic [31:0] clk_div_q;
   logic [2:0]  ctrl_q;
   logic [3:0]  flags_q, flags_d;   // {tx_overflow, parity, framing, overrun}

   logic [1:0]  reg_idx;
   logic        wr_lane0, data_wr, data_pop;

   logic [DATA_BITS-1:0] tx_head, rx_head;
   logic                 tx_full, tx_empty, rx_full, rx_empty;
   logic [CW-1:0]        tx_count, rx_count;

   tx_state_e            tx_state_q;
   logic [31:0]          tx_cnt_q;
   logic [DATA_BITS-1:0] tx_shift_q;
   logic [BW-1:0]        tx_bit_q;
   logic                 tx_q, tx_par_en_q, tx_par_q, tx_two_stop_q, tx_stop2_q;
   logic                 tx_tick, tx_load, tx_idle;

   logic                 rx_s1_q, rx_s2_q;
   rx_state_e            rx_state_q;
   logic [31:0]          rx_cnt_q;
   logic [DATA_BITS-1:0] rx_shift_q;
   logic [BW-1:0]        rx_bit_q;
   logic                 rx_par_en_q, rx_par_odd_q, rx_par_bit_q;
   logic                 rx_push_q, rx_ferr_q, rx_perr_q;

   logic [15:0] status;
   logic [63:0] rd_data;
   logic        unused_bits;

   assign reg_idx  = bus.address_in[4:3];
   assign wr_lane0 = bus.sel_in && bus.write_mask_in[0];
   assign data_wr  = wr_lane0 && (reg_idx == REG_DATA);
   assign data_pop = bus.sel_in && bus.read_in && (reg_idx == REG_DATA);

   uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .reset(reset),
      .push_i(data_wr), .push_data_i(bus.write_value_in[DATA_BITS-1:0]),
      .pop_i(tx_load), .head_o(tx_head),
      .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_count)
   );

   uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .reset(reset),
      .push_i(rx_push_q), .push_data_i(rx_shift_q),
      .pop_i(data_pop), .head_o(rx_head),
      .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_count)
   );

   // software-visible configuration registers
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_div_q <= CLK_DIV_RESET;
         ctrl_q    <= '0;
      end else if (bus.sel_in && (reg_idx == REG_CLK_DIV)) begin
         if (bus.write_mask_in[0]) clk_div_q[15:0]  <= bus.write_value_in[15:0];
         if (bus.write_mask_in[1]) clk_div_q[31:16] <= bus.write_value_in[31:16];
      end else if (wr_lane0 && (reg_idx == REG_CTRL)) begin
         ctrl_q <= bus.write_value_in[2:0];
      end
   end

   // sticky error flags: write-1-to-clear, a hardware set in the same cycle wins
   always_comb begin
      flags_d = flags_q;
      if (wr_lane0 && (reg_idx == REG_STATUS)) flags_d = flags_q & ~bus.write_value_in[6:3];
      if (rx_push_q && rx_full && !data_pop) flags_d[0] = 1'b1;
      if (rx_ferr_q)                         flags_d[1] = 1'b1;
      if (rx_perr_q)                         flags_d[2] = 1'b1;
      if (data_wr && tx_full && !tx_load)    flags_d[3] = 1'b1;
   end

   // sticky flag register
   always_ff @(posedge clk) begin
      if (reset) flags_q <= '0;
      else       flags_q <= flags_d;
   end

   // transmitter is ready for a new frame when idle, or right after its last stop bit
   assign tx_tick = (tx_cnt_q == '0);
   assign tx_load = !tx_empty && ((tx_state_q == TX_IDLE) ||
                    ((tx_state_q == TX_STOP) && tx_tick && (!tx_two_stop_q || tx_stop2_q)));
   assign tx_idle = tx_empty && (tx_state_q == TX_IDLE);

   // transmit shifter; bit period reloaded from CLK_DIV at every bit boundary
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state_q    <= TX_IDLE;
         tx_q          <= 1'b1;
         tx_cnt_q      <= '0;
         tx_shift_q    <= '0;
         tx_bit_q      <= '0;
         tx_par_en_q   <= 1'b0;
         tx_par_q      <= 1'b0;
         tx_two_stop_q <= 1'b0;
         tx_stop2_q    <= 1'b0;
      end else if (tx_load) begin
         tx_state_q    <= TX_START;
         tx_q          <= 1'b0;
         tx_cnt_q      <= clk_div_q;
         tx_shift_q    <= tx_head;
         tx_bit_q      <= '0;
         tx_par_en_q   <= ctrl_q[CTRL_PARITY_EN];
         tx_par_q      <= (^tx_head) ^ ctrl_q[CTRL_PARITY_ODD];
         tx_two_stop_q <= ctrl_q[CTRL_TWO_STOP];
         tx_stop2_q    <= 1'b0;
      end else if (tx_state_q != TX_IDLE) begin
         if (!tx_tick) begin
            tx_cnt_q <= tx_cnt_q - 32'd1;
         end else begin
            tx_cnt_q <= clk_div_q;
            case (tx_state_q)
               TX_START: begin
                  tx_state_q <= TX_DATA;
                  tx_q       <= tx_shift_q[0];
                  tx_shift_q <= tx_shift_q >> 1;
               end
               TX_DATA: begin
                  if (tx_bit_q == BW'(DATA_BITS - 1)) begin
                     tx_state_q <= tx_par_en_q ? TX_PARITY : TX_STOP;
                     tx_q       <= tx_par_en_q ? tx_par_q : 1'b1;
                  end else begin
                     tx_bit_q   <= tx_bit_q + 1'b1;
                     tx_q       <= tx_shift_q[0];
                     tx_shift_q <= tx_shift_q >> 1;
                  end
               end
               TX_PARITY: begin
                  tx_state_q <= TX_STOP;
                  tx_q       <= 1'b1;
               end
               default: begin
                  if (tx_two_stop_q && !tx_stop2_q) tx_stop2_q <= 1'b1;
                  else                              tx_state_q <= TX_IDLE;
               end
            endcase
         end
      end
   end

   // two-flop synchroniser for the asynchronous serial input
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_s1_q <= 1'b1;
         rx_s2_q <= 1'b1;
      end else begin
         rx_s1_q <= rx_in;
         rx_s2_q <= rx_s1_q;
      end
   end

   // receive sampler: half-bit start check, then mid-bit sampling; result strobes one cycle later
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_state_q   <= RX_IDLE;
         rx_cnt_q     <= '0;
         rx_shift_q   <= '0;
         rx_bit_q     <= '0;
         rx_par_en_q  <= 1'b0;
         rx_par_odd_q <= 1'b0;
         rx_par_bit_q <= 1'b0;
         rx_push_q    <= 1'b0;
         rx_ferr_q    <= 1'b0;
         rx_perr_q    <= 1'b0;
      end else begin
         rx_push_q <= 1'b0;
         rx_ferr_q <= 1'b0;
         rx_perr_q <= 1'b0;
         if (rx_state_q == RX_IDLE) begin
            if (!rx_s2_q) begin
               rx_state_q   <= RX_START;
               rx_cnt_q     <= clk_div_q >> 1;
               rx_par_en_q  <= ctrl_q[CTRL_PARITY_EN];
               rx_par_odd_q <= ctrl_q[CTRL_PARITY_ODD];
            end
         end else if (rx_cnt_q != '0) begin
            rx_cnt_q <= rx_cnt_q - 32'd1;
         end else begin
            rx_cnt_q <= clk_div_q;
            case (rx_state_q)
               RX_START: begin
                  if (rx_s2_q) begin
                     rx_state_q <= RX_IDLE;
                  end else begin
                     rx_state_q <= RX_DATA;
                     rx_bit_q   <= '0;
                  end
               end
               RX_DATA: begin
                  rx_shift_q <= {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
                  if (rx_bit_q == BW'(DATA_BITS - 1)) rx_state_q <= rx_par_en_q ? RX_PARITY : RX_STOP;
                  else                                rx_bit_q   <= rx_bit_q + 1'b1;
               end
               RX_PARITY: begin
                  rx_par_bit_q <= rx_s2_q;
                  rx_state_q   <= RX_STOP;
               end
               default: begin
                  rx_state_q <= RX_IDLE;
                  if (!rx_s2_q)
                     rx_ferr_q <= 1'b1;
                  else if (rx_par_en_q && (rx_par_bit_q != ((^rx_shift_q) ^ rx_par_odd_q)))
                     rx_perr_q <= 1'b1;
                  else
                     rx_push_q <= 1'b1;
               end
            endcase
         end
      end
   end

   // register read mux, combinational and zero when not selected
   always_comb begin
      status                  = '0;
      status[ST_TX_NOT_FULL]  = !tx_full;
      status[ST_RX_NOT_EMPTY] = !rx_empty;
      status[ST_TX_IDLE]      = tx_idle;
      status[ST_RX_OVERRUN]   = flags_q[0];
      status[ST_RX_FRAMING]   = flags_q[1];
      status[ST_RX_PARITY]    = flags_q[2];
      status[ST_TX_OVERFLOW]  = flags_q[3];
      status[15:8]            = 8'(rx_count);
      rd_data = '0;
      if (bus.sel_in) begin
         case (reg_idx)
            REG_CLK_DIV: rd_data = {32'd0, clk_div_q};
            REG_STATUS:  rd_data = {48'd0, status};
            REG_DATA:    rd_data = {{48{rx_empty}}, rx_empty ? 16'd0 : 16'(rx_head)};
            default:     rd_data = {61'd0, ctrl_q};
         endcase
      end
   end

   assign bus.read_value_out = rd_data;
   assign tx_out             = tx_q;

   assign unused_bits = ^{bus.address_in[63:5], bus.address_in[2:0], bus.write_value_in[63:32],
                          bus.write_mask_in[3:2], tx_count};
endmodule

// File: tb/tb_uart_fifo.sv
// tb/tb_uart_fifo.sv - randomized self-checking bench for uart_fifo with a queue-based reference model
module tb_uart_fifo;
   import uart_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic rx_drv;
   logic loop_en;
   logic rx_line;
   logic tx_line;
   int   total = 0;
   int   bad   = 0;
   logic [7:0] exp_q[$];

   uart_fifo_if bus();

   uart_fifo #(.DATA_BITS(8), .FIFO_DEPTH(16), .CLK_DIV_RESET(32'd0)) dut (
      .clk(clk), .reset(reset), .rx_in(rx_line), .tx_out(tx_line), .bus(bus)
   );

   assign rx_line = loop_en ? tx_line : rx_drv;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_wr(input logic [1:0] idx, input logic [3:0] mask, input logic [63:0] val);
      @(negedge clk);
      bus.sel_in         = 1'b1;
      bus.read_in        = 1'b0;
      bus.address_in     = {59'd0, idx, 3'd0};
      bus.write_mask_in  = mask;
      bus.write_value_in = val;
      @(posedge clk);
      #1;
      bus.sel_in        = 1'b0;
      bus.write_mask_in = 4'd0;
   endtask

   task automatic bus_rd(input logic [1:0] idx, input logic pop, output logic [63:0] val);
      @(negedge clk);
      bus.sel_in        = 1'b1;
      bus.read_in       = pop;
      bus.address_in    = {59'd0, idx, 3'd0};
      bus.write_mask_in = 4'd0;
      #1;
      val = bus.read_value_out;
      @(posedge clk);
      #1;
      bus.sel_in  = 1'b0;
      bus.read_in = 1'b0;
   endtask

   task automatic drive_frame(input logic [7:0] d, input int div, input bit pe, input bit par_flip, input bit stop_v);
      bit bits[$];
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(d[i]);
      if (pe) bits.push_back((^d) ^ par_flip);
      bits.push_back(stop_v);
      @(posedge clk);
      #1;
      foreach (bits[k]) begin
         rx_drv = bits[k];
         cycles(div + 1);
      end
      rx_drv = 1'b1;
   endtask

   task automatic drain_check(input string tag);
      logic [63:0] v;
      while (exp_q.size() > 0) begin
         bus_rd(REG_DATA, 1'b1, v);
         chk(tag, v, {56'd0, exp_q.pop_front()});
      end
   endtask

   initial begin
      logic [63:0] v;
      logic [9:0]  fr;
      logic [7:0]  b;
      int          div, n, ctl, fl;
      bit          seen;

      reset = 1'b1;
      rx_drv = 1'b1;
      loop_en = 1'b0;
      bus.sel_in = 1'b0;
      bus.read_in = 1'b0;
      bus.address_in = 64'd0;
      bus.write_mask_in = 4'd0;
      bus.write_value_in = 64'd0;
      cycles(3);
      reset = 1'b0;
      cycles(2);

      bus.address_in = {59'd0, REG_DATA, 3'd0};
      #1;
      chk("unselected_read", bus.read_value_out, 64'd0);
      chk("reset_tx_out", tx_line, 1);
      bus_rd(REG_CLK_DIV, 1'b0, v); chk("reset_clk_div", v, 64'd0);
      bus_rd(REG_STATUS, 1'b0, v);  chk("reset_status", v, 64'h5);
      bus_rd(REG_DATA, 1'b0, v);    chk("reset_data", v, 64'hFFFF_FFFF_FFFF_0000);
      bus_rd(REG_CTRL, 1'b0, v);    chk("reset_ctrl", v, 64'd0);

      // single 0xA5 frame, CLK_DIV=3, no parity, one stop
      bus_wr(REG_CLK_DIV, 4'b0011, 64'd3);
      bus_wr(REG_CTRL, 4'b0001, 64'd0);
      bus_wr(REG_DATA, 4'b0001, 64'hA5);
      fr = {1'b1, 8'hA5, 1'b0};
      for (int c = 0; c < 40; c++) begin
         cycles(1);
         chk($sformatf("tx_a5_cycle%0d", c), tx_line, fr[c / 4]);
      end
      bus_rd(REG_STATUS, 1'b0, v); chk("tx_busy_end_of_stop", v[ST_TX_IDLE], 0);
      bus_rd(REG_STATUS, 1'b0, v); chk("tx_idle_after_frame", v[ST_TX_IDLE], 1);

      // loopback with odd parity
      loop_en = 1'b1;
      bus_wr(REG_CTRL, 4'b0001, 64'h3);
      exp_q = '{8'h00, 8'hFF, 8'h3C};
      foreach (exp_q[k]) bus_wr(REG_DATA, 4'b0001, {56'd0, exp_q[k]});
      cycles(3 * 11 * 4 + 30);
      bus_rd(REG_STATUS, 1'b0, v); chk("loop_odd_status", v, 64'h307);
      drain_check("loop_odd_data");
      bus_rd(REG_DATA, 1'b0, v); chk("loop_odd_empty", v, 64'hFFFF_FFFF_FFFF_0000);

      // randomized loopback rounds
      for (int r = 0; r < 5; r++) begin
         div = $urandom_range(1, 6);
         ctl = $urandom_range(0, 7);
         n   = $urandom_range(1, 6);
         fl  = 10 + (ctl & 1) + ((ctl >> 2) & 1);
         bus_wr(REG_CLK_DIV, 4'b0011, 64'(div));
         bus_wr(REG_CTRL, 4'b0001, 64'(ctl));
         for (int k = 0; k < n; k++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            bus_wr(REG_DATA, 4'b0001, {56'd0, b});
         end
         cycles(n * fl * (div + 1) + 4 * (div + 1) + 20);
         bus_rd(REG_STATUS, 1'b0, v);
         chk($sformatf("rand%0d_status", r), v, 64'((n << 8) | 7));
         drain_check($sformatf("rand%0d_data", r));
      end

      // 17 frames into a 16-deep RX FIFO
      bus_wr(REG_CLK_DIV, 4'b0011, 64'd1);
      bus_wr(REG_CTRL, 4'b0001, 64'd0);
      for (int k = 0; k < 17; k++) begin
         b = 8'($urandom);
         if (k < 16) exp_q.push_back(b);
         bus_wr(REG_DATA, 4'b0001, {56'd0, b});
      end
      cycles(17 * 20 + 30);
      bus_rd(REG_STATUS, 1'b0, v); chk("overrun_status", v, 64'h100F);
      drain_check("overrun_data");
      bus_wr(REG_STATUS, 4'b0001, 64'h08);
      bus_rd(REG_STATUS, 1'b0, v); chk("overrun_cleared", v, 64'h5);

      // stop bit low, then bad parity, then good parity
      loop_en = 1'b0;
      bus_wr(REG_CLK_DIV, 4'b0011, 64'd3);
      drive_frame(8'h5A, 3, 1'b0, 1'b0, 1'b0);
      cycles(20);
      bus_rd(REG_STATUS, 1'b0, v); chk("framing_status", v, 64'h15);
      bus_wr(REG_STATUS, 4'b0001, 64'h10);
      bus_wr(REG_CTRL, 4'b0001, 64'h1);
      drive_frame(8'h33, 3, 1'b1, 1'b1, 1'b1);
      cycles(20);
      bus_rd(REG_STATUS, 1'b0, v); chk("parity_status", v, 64'h25);
      bus_wr(REG_STATUS, 4'b0001, 64'h20);
      drive_frame(8'hC4, 3, 1'b1, 1'b0, 1'b1);
      cycles(20);
      bus_rd(REG_STATUS, 1'b0, v); chk("good_parity_status", v, 64'h107);
      exp_q.push_back(8'hC4);
      drain_check("good_parity_data");

      // one-cycle glitch, CLK_DIV=7, then a real frame
      bus_wr(REG_CLK_DIV, 4'b0011, 64'd7);
      bus_wr(REG_CTRL, 4'b0001, 64'd0);
      rx_drv = 1'b0;
      cycles(1);
      rx_drv = 1'b1;
      cycles(40);
      bus_rd(REG_STATUS, 1'b0, v); chk("glitch_status", v, 64'h5);
      drive_frame(8'h96, 7, 1'b0, 1'b0, 1'b1);
      cycles(20);
      exp_q.push_back(8'h96);
      drain_check("after_glitch_data");

      // TX overflow, then reset in the middle of a frame
      bus_wr(REG_CLK_DIV, 4'b0011, 64'd3);
      for (int k = 0; k < 20; k++) bus_wr(REG_DATA, 4'b0001, 64'(k));
      bus_rd(REG_STATUS, 1'b0, v); chk("tx_overflow_status", v, 64'h40);
      seen = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
         cycles(1);
         if (tx_line == 1'b0) seen = 1'b1;
      end
      chk("tx_low_seen", seen, 1);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("reset_mid_frame_tx", tx_line, 1);
      reset = 1'b0;
      cycles(10);
      chk("post_reset_tx_high", tx_line, 1);
      bus_rd(REG_STATUS, 1'b0, v);  chk("post_reset_status", v, 64'h5);
      bus_rd(REG_CLK_DIV, 1'b0, v); chk("post_reset_clk_div", v, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
